iobus_uart_tx: RTL and testbench



---
 rtl/iobus_uart_tx.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_iobus_uart_tx.sv | 518 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iobus_uart_tx.sv
// iobus_uart_tx: memory-mapped UART transmitter on the MCU IOBUS.
//
// Stores to the DATA register push bytes into a small FIFO. An FSM pops the
// FIFO and sends each byte 8N1, LSB first, on TX. Back-to-back bytes go out
// with no idle gap between frames.
//
// Register window at BASE_ADDR (word aligned, IOBUS_ADDR[1:0] ignored):
//   0x0 DATA   (W)  push IOBUS_OUT[7:0]; reads 0
//   0x4 STATUS (R)  bit0 busy, bit1 full, bit2 empty, bit3 overflow (sticky),
//                   bits[15:8] FIFO count. Write IOBUS_OUT[3]=1 clears overflow
//   0x8 CTRL   (RW) bit0 irq_en, bit1 odd parity (parity build only)
//   0xC        reads 0, writes ignored
//
// Optional feature macro: UART_TX_PARITY_EN
//   When defined, a parity bit is sent between the data bits and the stop bit.
//   The parity is even by default and odd when CTRL bit1 is set.
//
// Ports:
//   CLK, RST    system clock; synchronous active-high reset
//   IOBUS_ADDR  byte address from the core
//   IOBUS_OUT   write data from the core
//   IOBUS_WR    one-cycle write strobe
//   RD_DATA     combinational read data (0 when the address is not in the window)
//   HIT         combinational window decode for the IOBUS_IN mux
//   TX          registered serial output, idle high
//   IRQ         registered level interrupt (irq_en & FIFO empty & idle)
module iobus_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h1100_0000,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] RD_DATA,
  output logic        HIT,
  output logic        TX,
  output logic        IRQ
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = AddrW + 1;
  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);

  localparam logic [BaudW-1:0] BaudMax = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0]  CntFull = CntW'(FIFO_DEPTH);

  localparam logic [1:0] RegData   = 2'd0;
  localparam logic [1:0] RegStatus = 2'd1;
  localparam logic [1:0] RegCtrl   = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic [1:0] reg_sel;
  logic       wr_en;
  logic       push;
  logic       clr_ovf;
  logic       ctrl_wr;

  assign HIT     = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
  assign reg_sel = IOBUS_ADDR[3:2];
  assign wr_en   = IOBUS_WR & HIT;
  assign push    = wr_en & (reg_sel == RegData);
  assign clr_ovf = wr_en & (reg_sel == RegStatus) & IOBUS_OUT[3];
  assign ctrl_wr = wr_en & (reg_sel == RegCtrl);

  // ---------------------------------------------------------------------------
  // Byte FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             fifo_empty, fifo_full;
  logic             pop;
  logic             push_ok;
  logic [7:0]       fifo_head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntFull);
  // A push into a full FIFO is still accepted if the same cycle frees a slot.
  assign push_ok    = push & (~fifo_full | pop);
  assign fifo_head  = fifo_mem[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_q] <= IOBUS_OUT[7:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AddrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AddrW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control / status registers
  // ---------------------------------------------------------------------------
  logic ovf_q;
  logic irq_en_q;
  logic odd_par;

  always_ff @(posedge CLK) begin
    if (RST) begin
      ovf_q    <= 1'b0;
      irq_en_q <= 1'b0;
    end else begin
      if (push && fifo_full && !pop) begin
        ovf_q <= 1'b1;
      end else if (clr_ovf) begin
        ovf_q <= 1'b0;
      end
      if (ctrl_wr) begin
        irq_en_q <= IOBUS_OUT[0];
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  localparam bit ParityEn = 1'b1;

  logic odd_par_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      odd_par_q <= 1'b0;
    end else if (ctrl_wr) begin
      odd_par_q <= IOBUS_OUT[1];
    end
  end

  assign odd_par = odd_par_q;
`else
  localparam bit ParityEn = 1'b0;

  assign odd_par = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       data_q, data_d;
  logic             tx_q, tx_d;
  logic             irq_q, irq_d;
  logic             baud_last;

  assign baud_last = (baud_q == BaudMax);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    data_d  = data_q;
    pop     = 1'b0;

    case (state_q)
      StIdle: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          data_d  = fifo_head;
          state_d = StStart;
        end
      end

      StStart: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = StData;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end

      StData: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ParityEn ? StParity : StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end

      StParity: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = StStop;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end

      StStop: begin
        if (baud_last) begin
          baud_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            pop     = 1'b1;
            data_d  = fifo_head;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end

      default: begin
        baud_d  = '0;
        state_d = StIdle;
      end
    endcase
  end

  // TX is registered from the next-state view so the line level always
  // matches the state the FSM is in during that cycle.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = data_d[bit_d];
      StParity: tx_d = (^data_d) ^ odd_par;
      default:  tx_d = 1'b1;
    endcase
  end

  assign irq_d = irq_en_q & fifo_empty & (state_q == StIdle);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      irq_q   <= irq_d;
    end
  end

  assign TX  = tx_q;
  assign IRQ = irq_q;

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [31:0] count_ext;
  logic [31:0] status_word;
  logic [31:0] ctrl_word;
  logic        busy;

  assign busy        = (state_q != StIdle);
  // Count field is 8 bits wide; a 256-deep FIFO reports full via bit1.
  assign count_ext   = 32'(count_q);
  assign status_word = {16'h0, count_ext[7:0], 4'h0, ovf_q, fifo_empty, fifo_full, busy};
  assign ctrl_word   = {30'h0, odd_par, irq_en_q};

  always_comb begin
    RD_DATA = '0;
    if (HIT) begin
      case (reg_sel)
        RegStatus: RD_DATA = status_word;
        RegCtrl:   RD_DATA = ctrl_word;
        default:   RD_DATA = '0;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{IOBUS_ADDR[1:0], IOBUS_OUT[31:8], count_ext[31:8]};

endmodule

// File: tb/tb_iobus_uart_tx.sv
// Testbench for iobus_uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=8.
// It also covers the parity frame when UART_TX_PARITY_EN is defined.
module tb_iobus_uart_tx;

  localparam logic [31:0] Base  = 32'h1100_0000;
  localparam int          Cpb   = 4;
  localparam int          Depth = 8;
`ifdef UART_TX_PARITY_EN
  localparam bit ParEn     = 1'b1;
  localparam int FrameBits = 11;
`else
  localparam bit ParEn     = 1'b0;
  localparam int FrameBits = 10;
`endif
  localparam int FrameLen = FrameBits * Cpb;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rd_data;
  logic        hit;
  logic        tx;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;
  bit odd_mode = 1'b0;
  logic [7:0] exp_q[$];

  iobus_uart_tx #(
    .BASE_ADDR   (Base),
    .CLKS_PER_BIT(Cpb),
    .FIFO_DEPTH  (Depth)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .IOBUS_ADDR(addr),
    .IOBUS_OUT (wdata),
    .IOBUS_WR  (wr),
    .RD_DATA   (rd_data),
    .HIT       (hit),
    .TX        (tx),
    .IRQ       (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives a store during the current cycle and returns one cycle later.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr    = 1'b1;
    step();
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic h);
    addr = a;
    wr   = 1'b0;
    #1;
    d = rd_data;
    h = hit;
  endtask

  // Line level expected at cycle idx of a frame carrying byte b.
  function automatic logic exp_bit(input logic [7:0] b, input bit odd, input int idx);
    int slot;
    slot = idx / Cpb;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (ParEn && slot == 9) return (^b) ^ odd;
    return 1'b1;
  endfunction

  // Sends one byte from an idle, empty state and checks the waveform cycle by
  // cycle. The task returns on the first idle cycle after the frame.
  task automatic send_check(input logic [7:0] b, output int mism, output int busy_bad,
                            output logic par_seen);
    logic [31:0] d;
    logic        h;
    mism     = 0;
    busy_bad = 0;
    par_seen = 1'bx;
    bus_write(Base, {24'h0, b});
    if (tx !== 1'b1) mism++;
    step();
    for (int i = 0; i < FrameLen; i++) begin
      if (tx !== exp_bit(b, odd_mode, i)) mism++;
      if (ParEn && i == 9 * Cpb) par_seen = tx;
      bus_read(Base + 32'h4, d, h);
      if (d[0] !== 1'b1) busy_bad++;
      step();
    end
    if (tx !== 1'b1) mism++;
    bus_read(Base + 32'h4, d, h);
    if (d[0] !== 1'b0) busy_bad++;
  endtask

  // Receives n frames and checks them against exp_q. After the first frame,
  // every later frame must start on the cycle after the previous stop bit.
  task automatic rx_frames(input int n, input int first_timeout);
    for (int f = 0; f < n; f++) begin
      int          waited;
      int          limit;
      logic [10:0] bits;
      bit          stable;
      logic [7:0]  want;
      waited = 0;
      limit  = (f == 0) ? first_timeout : 0;
      while (tx !== 1'b0 && waited < limit) begin
        step();
        waited++;
      end
      n_checks++;
      if (tx !== 1'b0) begin
        $display("FAIL rx_start frame %0d: tx=%b, required start bit 0", f, tx);
        n_fail++;
        return;
      end
      stable = 1'b1;
      bits   = '0;
      for (int b = 0; b < FrameBits; b++) begin
        logic v;
        v = tx;
        for (int j = 0; j < Cpb; j++) begin
          if (tx !== v) stable = 1'b0;
          step();
        end
        bits[b] = v;
      end
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_checks++;
      if (stable !== 1'b1) begin
        $display("FAIL rx_stable frame %0d: bit period not constant, got 0 required 1", f);
        n_fail++;
      end
      n_checks++;
      if (bits[8:1] !== want) begin
        $display("FAIL rx_data frame %0d: got %h required %h", f, bits[8:1], want);
        n_fail++;
      end
      n_checks++;
      if (bits[FrameBits-1] !== 1'b1) begin
        $display("FAIL rx_stop frame %0d: got %b required 1", f, bits[FrameBits-1]);
        n_fail++;
      end
      if (ParEn) begin
        n_checks++;
        if (bits[9] !== ((^want) ^ odd_mode)) begin
          $display("FAIL rx_parity frame %0d: got %b required %b", f, bits[9],
                   (^want) ^ odd_mode);
          n_fail++;
        end
      end
    end
  endtask

  task automatic check_quiet(input string name, input int cycles);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      if (tx !== 1'b1) bad++;
      step();
    end
    n_checks++;
    if (bad != 0) begin
      $display("FAIL %s: %0d cycles with tx low, required 0", name, bad);
      n_fail++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        h;
    rst   = 1'b1;
    wr    = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;
    repeat (3) step();
    rst = 1'b0;
    step();
    n_checks++;
    if (tx !== 1'b1) begin
      $display("FAIL reset_tx: got %b required 1", tx);
      n_fail++;
    end
    n_checks++;
    if (irq !== 1'b0) begin
      $display("FAIL reset_irq: got %b required 0", irq);
      n_fail++;
    end
    bus_read(Base + 32'h4, d, h);
    n_checks++;
    if (d !== 32'h0000_0004) begin
      $display("FAIL reset_status: got %h required 00000004", d);
      n_fail++;
    end
    bus_read(Base + 32'h8, d, h);
    n_checks++;
    if (d !== 32'h0) begin
      $display("FAIL reset_ctrl: got %h required 00000000", d);
      n_fail++;
    end
  endtask

  task automatic test_single();
    logic [7:0] bytes [4];
    int         mism;
    int         busy_bad;
    logic       par;
    bytes[0] = 8'h55;
    for (int i = 1; i < 4; i++) bytes[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) begin
      send_check(bytes[i], mism, busy_bad, par);
      n_checks++;
      if (mism != 0) begin
        $display("FAIL single_wave byte %h: %0d bad cycles, required 0", bytes[i], mism);
        n_fail++;
      end
      n_checks++;
      if (busy_bad != 0) begin
        $display("FAIL single_busy byte %h: %0d bad cycles, required 0", bytes[i], busy_bad);
        n_fail++;
      end
      step();
    end
  endtask

  // Burst of n stores in n cycles from idle; the model expects the first
  // Depth+1 bytes to be sent (one is popped right after the first store)
  // and the rest to be dropped.
  task automatic burst(input int n, input string name);
    logic [7:0]  b [16];
    int          kept;
    bit          ovf_exp;
    logic [31:0] d;
    logic        h;
    int          cnt_exp;
    kept    = (n > Depth + 1) ? Depth + 1 : n;
    ovf_exp = (n > Depth + 1);
    cnt_exp = kept - 1;
    for (int i = 0; i < n; i++) b[i] = 8'($urandom);
    for (int i = 0; i < kept; i++) exp_q.push_back(b[i]);
    fork
      rx_frames(kept, 10);
      begin
        logic [31:0] st_exp;
        for (int i = 0; i < n; i++) begin
          addr  = Base;
          wdata = {24'h0, b[i]};
          wr    = 1'b1;
          step();
        end
        wr = 1'b0;
        st_exp = (32'(cnt_exp) << 8) | (ovf_exp ? 32'h8 : 32'h0)
               | ((cnt_exp == Depth) ? 32'h2 : 32'h0) | 32'h1;
        bus_read(Base + 32'h4, d, h);
        n_checks++;
        if (d !== st_exp) begin
          $display("FAIL %s_status: got %h required %h", name, d, st_exp);
          n_fail++;
        end
        if (ovf_exp) begin
          bus_write(Base + 32'h4, 32'h8);
          bus_read(Base + 32'h4, d, h);
          n_checks++;
          if (d[3] !== 1'b0) begin
            $display("FAIL %s_ovf_clear: got %b required 0", name, d[3]);
            n_fail++;
          end
        end
      end
    join
    n_checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL %s_drain: %0d bytes unsent, required 0", name, exp_q.size());
      n_fail++;
      exp_q.delete();
    end
    check_quiet({name, "_quiet"}, 2 * FrameLen);
  endtask

  task automatic test_back_to_back();
    burst(9, "b2b");
  endtask

  task automatic test_overflow();
    burst(10, "ovf");
  endtask

  task automatic test_irq();
    int bad;
    int wbad;
    logic [7:0] b;
    logic [31:0] d;
    logic        h;
    b = 8'($urandom);
    bus_write(Base + 32'h8, 32'h1);
    n_checks++;
    if (irq !== 1'b0) begin
      $display("FAIL irq_en_lag: got %b required 0", irq);
      n_fail++;
    end
    step();
    n_checks++;
    if (irq !== 1'b1) begin
      $display("FAIL irq_idle: got %b required 1", irq);
      n_fail++;
    end
    bus_write(Base, {24'h0, b});
    step();
    bad  = 0;
    wbad = 0;
    for (int i = 0; i < FrameLen; i++) begin
      if (irq !== 1'b0) bad++;
      if (tx !== exp_bit(b, odd_mode, i)) wbad++;
      step();
    end
    n_checks++;
    if (bad != 0 || irq !== 1'b0) begin
      $display("FAIL irq_frame: %0d high cycles, required 0", bad + (irq === 1'b1 ? 1 : 0));
      n_fail++;
    end
    n_checks++;
    if (wbad != 0) begin
      $display("FAIL irq_wave: %0d bad cycles, required 0", wbad);
      n_fail++;
    end
    step();
    n_checks++;
    if (irq !== 1'b1) begin
      $display("FAIL irq_after: got %b required 1", irq);
      n_fail++;
    end
    bus_write(Base + 32'h8, 32'h0);
    step();
    n_checks++;
    if (irq !== 1'b0) begin
      $display("FAIL irq_disable: got %b required 0", irq);
      n_fail++;
    end
    bus_read(Base + 32'h8, d, h);
    n_checks++;
    if (d !== 32'h0) begin
      $display("FAIL irq_ctrl_read: got %h required 00000000", d);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic        h;
    int          ibad;
    bus_write(Base + 32'h8, 32'h1);
    bus_write(Base, 32'hA5);
    bus_write(Base, 32'h3C);
    bus_write(Base, 32'h0F);
    repeat (5) step();
    bus_read(Base + 32'h4, d, h);
    n_checks++;
    if (d[0] !== 1'b1) begin
      $display("FAIL rstmid_busy: got %b required 1", d[0]);
      n_fail++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (tx !== 1'b1) begin
      $display("FAIL rstmid_tx: got %b required 1", tx);
      n_fail++;
    end
    n_checks++;
    if (irq !== 1'b0) begin
      $display("FAIL rstmid_irq: got %b required 0", irq);
      n_fail++;
    end
    bus_read(Base + 32'h4, d, h);
    n_checks++;
    if (d !== 32'h0000_0004) begin
      $display("FAIL rstmid_status: got %h required 00000004", d);
      n_fail++;
    end
    bus_read(Base + 32'h8, d, h);
    n_checks++;
    if (d !== 32'h0) begin
      $display("FAIL rstmid_ctrl: got %h required 00000000", d);
      n_fail++;
    end
    ibad = 0;
    for (int i = 0; i < FrameLen; i++) begin
      if (irq !== 1'b0) ibad++;
      step();
    end
    n_checks++;
    if (ibad != 0) begin
      $display("FAIL rstmid_irq_after: %0d high cycles, required 0", ibad);
      n_fail++;
    end
    check_quiet("rstmid_flushed", 2 * FrameLen);
  endtask

  task automatic test_addr();
    logic [31:0] d;
    logic        h;
    logic [31:0] ctrl_exp;
    bus_read(Base + 32'hC, d, h);
    n_checks++;
    if (d !== 32'h0 || h !== 1'b1) begin
      $display("FAIL addr_0xC: got data %h hit %b required 00000000 hit 1", d, h);
      n_fail++;
    end
    bus_read(Base, d, h);
    n_checks++;
    if (d !== 32'h0 || h !== 1'b1) begin
      $display("FAIL addr_data_read: got data %h hit %b required 00000000 hit 1", d, h);
      n_fail++;
    end
    bus_read(Base + 32'h6, d, h);
    n_checks++;
    if (d !== 32'h0000_0004) begin
      $display("FAIL addr_low_bits: got %h required 00000004", d);
      n_fail++;
    end
    bus_read(Base + 32'h10, d, h);
    n_checks++;
    if (d !== 32'h0 || h !== 1'b0) begin
      $display("FAIL addr_miss: got data %h hit %b required 00000000 hit 0", d, h);
      n_fail++;
    end
    bus_write(Base + 32'h10, 32'h55);
    bus_write(Base + 32'h18, 32'h1);
    bus_write(Base + 32'hC, 32'hFF);
    bus_read(Base + 32'h4, d, h);
    n_checks++;
    if (d !== 32'h0000_0004) begin
      $display("FAIL addr_miss_write: got status %h required 00000004", d);
      n_fail++;
    end
    bus_read(Base + 32'h8, d, h);
    n_checks++;
    if (d !== 32'h0) begin
      $display("FAIL addr_miss_ctrl: got %h required 00000000", d);
      n_fail++;
    end
    check_quiet("addr_quiet", FrameLen);
    bus_write(Base + 32'h8, 32'hFFFF_FFFF);
    ctrl_exp = ParEn ? 32'h3 : 32'h1;
    bus_read(Base + 32'h8, d, h);
    n_checks++;
    if (d !== ctrl_exp) begin
      $display("FAIL ctrl_rw: got %h required %h", d, ctrl_exp);
      n_fail++;
    end
    bus_write(Base + 32'h8, 32'h0);
    step();
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int   mism;
    int   busy_bad;
    logic par;
    odd_mode = 1'b0;
    send_check(8'h07, mism, busy_bad, par);
    n_checks++;
    if (par !== 1'b1 || mism != 0 || busy_bad != 0) begin
      $display("FAIL parity_even: parity %b bad %0d busy_bad %0d, required 1 0 0",
               par, mism, busy_bad);
      n_fail++;
    end
    step();
    bus_write(Base + 32'h8, 32'h2);
    odd_mode = 1'b1;
    step();
    send_check(8'h07, mism, busy_bad, par);
    n_checks++;
    if (par !== 1'b0 || mism != 0 || busy_bad != 0) begin
      $display("FAIL parity_odd: parity %b bad %0d busy_bad %0d, required 0 0 0",
               par, mism, busy_bad);
      n_fail++;
    end
    step();
    bus_write(Base + 32'h8, 32'h0);
    odd_mode = 1'b0;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_irq();
    test_reset_mid();
    test_addr();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
